// File: rtl/keypad_operand_loader.sv
// Keypad operand loader: counts scanner nibble pulses into 16-bit operands, hands them to the MAC
// over valid/ack and captures the result. Define LOADER_OPC_EN to also collect a third operand (op_c).
module keypad_operand_loader #(
  parameter int WORD_W       = 16,
  parameter int NIBBLES      = 4,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic              Clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              key_ready,
  input  logic [WORD_W-1:0] key_word,
  output logic              KeyRd,
  output logic [WORD_W-1:0] op_a,
  output logic [WORD_W-1:0] op_b,
  output logic [WORD_W-1:0] op_c,
  output logic              op_valid,
  input  logic              op_ack,
  input  logic              mac_done,
  input  logic [WORD_W-1:0] mac_result,
  output logic [WORD_W-1:0] result,
  output logic              result_valid,
  output logic              timeout_err
);

  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIBBLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    COLLECT_A,
    COLLECT_B,
    COLLECT_C,
    ISSUE,
    WAIT_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NW-1:0]     nib_q, nib_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [WORD_W-1:0] op_a_q, op_a_d;
  logic [WORD_W-1:0] op_b_q, op_b_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              keyrd_q, keyrd_d;
  logic              op_valid_q, op_valid_d;
  logic              result_valid_q, result_valid_d;
  logic              timeout_q, timeout_d;
`ifdef LOADER_OPC_EN
  logic [WORD_W-1:0] op_c_q, op_c_d;
`endif

  // Pulses only count while KeyRd is already high, so the cycle right after reset release is deaf.
  logic accept;
  logic last_nib;
  assign accept   = key_ready && keyrd_q;
  assign last_nib = (nib_q == NIB_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    nib_d          = nib_q;
    wait_d         = wait_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    op_valid_d     = op_valid_q;
    result_valid_d = 1'b0;
    timeout_d      = timeout_q;
`ifdef LOADER_OPC_EN
    op_c_d         = op_c_q;
`endif

    if (clear) begin
      state_d    = COLLECT_A;
      nib_d      = '0;
      wait_d     = '0;
      op_valid_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT_A: begin
          if (accept) begin
            nib_d = nib_q + NW'(1);
            if (last_nib) begin
              op_a_d  = key_word;
              nib_d   = '0;
              state_d = COLLECT_B;
            end
          end
        end
        COLLECT_B: begin
          if (accept) begin
            nib_d = nib_q + NW'(1);
            if (last_nib) begin
              op_b_d  = key_word;
              nib_d   = '0;
`ifdef LOADER_OPC_EN
              state_d = COLLECT_C;
`else
              state_d = ISSUE;
`endif
            end
          end
        end
        COLLECT_C: begin
`ifdef LOADER_OPC_EN
          if (accept) begin
            nib_d = nib_q + NW'(1);
            if (last_nib) begin
              op_c_d  = key_word;
              nib_d   = '0;
              state_d = ISSUE;
            end
          end
`else
          state_d = COLLECT_A;
`endif
        end
        ISSUE: begin
          // op_valid rises one cycle after entry; ack is only honoured once it is visible.
          if (op_valid_q && op_ack) begin
            op_valid_d = 1'b0;
            wait_d     = '0;
            state_d    = WAIT_DONE;
          end else begin
            op_valid_d = 1'b1;
          end
        end
        WAIT_DONE: begin
          if (mac_done) begin
            result_d       = mac_result;
            result_valid_d = 1'b1;
            wait_d         = '0;
            state_d        = COLLECT_A;
          end else if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            wait_d    = '0;
            state_d   = COLLECT_A;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
        default: state_d = COLLECT_A;
      endcase
    end

    keyrd_d = (state_d == COLLECT_A) || (state_d == COLLECT_B) || (state_d == COLLECT_C);
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: operand/result registers are reset too, because these drive outputs that must read 0 after reset.
      state_q        <= COLLECT_A;
      nib_q          <= '0;
      wait_q         <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      result_q       <= '0;
      keyrd_q        <= 1'b0;
      op_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
`ifdef LOADER_OPC_EN
      op_c_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
      state_q        <= state_d;
      nib_q          <= nib_d;
      wait_q         <= wait_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      result_q       <= result_d;
      keyrd_q        <= keyrd_d;
      op_valid_q     <= op_valid_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
`ifdef LOADER_OPC_EN
      op_c_q         <= op_c_d;
`endif
    end
  end

  assign KeyRd        = keyrd_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_valid     = op_valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_q;
`ifdef LOADER_OPC_EN
  assign op_c         = op_c_q;
`else
  assign op_c         = '0;
`endif

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Scoreboard bench for keypad_operand_loader: stimulus pushes expected operand sets and results,
// a negedge monitor pops and compares whenever op_valid rises or result_valid pulses.
module tb_keypad_operand_loader;

  logic        Clock = 1'b0;
  logic        reset_n, clear, key_ready, op_ack, mac_done;
  logic [15:0] key_word, mac_result;
  logic        KeyRd, op_valid, result_valid, timeout_err;
  logic [15:0] op_a, op_b, op_c, result;

  keypad_operand_loader #(.WORD_W(16), .NIBBLES(4), .DONE_TIMEOUT(16)) dut (
    .Clock(Clock), .reset_n(reset_n), .clear(clear), .key_ready(key_ready), .key_word(key_word),
    .KeyRd(KeyRd), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_valid(op_valid), .op_ack(op_ack),
    .mac_done(mac_done), .mac_result(mac_result), .result(result), .result_valid(result_valid),
    .timeout_err(timeout_err)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } ops_t;

  ops_t        exp_ops[$];
  logic [15:0] exp_res[$];
  ops_t        mon_ops;
  logic [15:0] mon_res;
  logic        ov_prev = 1'b0;

  // Monitor: compare on every op_valid rise and every result_valid pulse.
  always @(negedge Clock) begin
    if (reset_n) begin
      if (op_valid && !ov_prev) begin
        if (exp_ops.size() == 0) check("unexpected op_valid", 48'd1, 48'd0);
        else begin
          mon_ops = exp_ops.pop_front();
          check("operands a/b/c", {op_a, op_b, op_c}, mon_ops);
        end
      end
      if (result_valid) begin
        if (exp_res.size() == 0) check("unexpected result_valid", 48'd1, 48'd0);
        else begin
          mon_res = exp_res.pop_front();
          check("result", 48'(result), 48'(mon_res));
        end
      end
    end
    ov_prev = op_valid;
  end

  // One pulse, then one idle cycle; returns at the negedge right after the sampling edge.
  task automatic pulse_key(input logic [15:0] w);
    @(negedge Clock);
    key_ready = 1'b1;
    key_word  = w;
    @(negedge Clock);
    key_ready = 1'b0;
    key_word  = 16'h0000;
  endtask

  // Intermediate nibble pulses carry distinct junk so any misalignment captures a wrong word.
  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 3; i++) pulse_key(16'hA000 | 16'(i));
    pulse_key(w);
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    ops_t e;
    e.a = a;
    e.b = b;
`ifdef LOADER_OPC_EN
    e.c = c;
`else
    e.c = 16'h0000;
`endif
    exp_ops.push_back(e);
    send_word(a);
    send_word(b);
`ifdef LOADER_OPC_EN
    send_word(c);
`endif
  endtask

  task automatic wait_op_valid();
    int n = 0;
    while (!op_valid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("op_valid arrives", 48'(op_valid), 48'd1);
  endtask

  task automatic do_ack();
    op_ack = 1'b1;
    @(negedge Clock);
    op_ack = 1'b0;
    check("op_valid drops after ack", 48'(op_valid), 48'd0);
  endtask

  task automatic mac(input logic [15:0] r);
    mac_done   = 1'b1;
    mac_result = r;
    @(negedge Clock);
    mac_done   = 1'b0;
    mac_result = 16'h0000;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; clear = 1'b0; key_ready = 1'b0; key_word = '0;
    op_ack = 1'b0; mac_done = 1'b0; mac_result = '0;

    // Reset state
    repeat (2) @(negedge Clock);
    check("reset flags", {44'd0, KeyRd, op_valid, result_valid, timeout_err}, 48'd0);
    check("reset op_a/op_b/result", {op_a, op_b, result}, 48'd0);
    reset_n = 1'b1;
    #1 check("KeyRd low before first edge", 48'(KeyRd), 48'd0);
    @(negedge Clock);
    check("KeyRd high after first edge", 48'(KeyRd), 48'd1);

    // Operand load with latency: op_valid two cycles after the last pulse
    load_ops(16'h3C00, 16'h4000, 16'h3800);
    check("op_valid 1 cycle after last key", 48'(op_valid), 48'd0);
    check("KeyRd low in ISSUE", 48'(KeyRd), 48'd0);
    @(negedge Clock);
    check("op_valid 2 cycles after last key", 48'(op_valid), 48'd1);

    // Hold 50 cycles without ack; stray key pulses in ISSUE must be ignored
    n = 0;
    for (int i = 0; i < 50; i++) begin
      key_ready = (i == 10 || i == 20);
      key_word  = 16'hBEEF;
      if (op_valid) n++;
      @(negedge Clock);
    end
    key_ready = 1'b0;
    key_word  = '0;
    check("op_valid held without ack", 48'(n), 48'd50);
    do_ack();
    check("KeyRd low in WAIT_DONE", 48'(KeyRd), 48'd0);
    pulse_key(16'h1234);
    pulse_key(16'h5678);
    exp_res.push_back(16'h4200);
    mac(16'h4200);
    check("KeyRd back after result", 48'(KeyRd), 48'd1);
    @(negedge Clock);
    check("result_valid one cycle", 48'(result_valid), 48'd0);

    // Next operand set needs a full 4 pulses per word despite earlier stray pulses
    load_ops(16'h4100, 16'h4400, 16'h3A00);
    wait_op_valid();
    do_ack();

    // Timeout after 16 cycles in WAIT_DONE
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("timeout cycle", 48'(n), 48'd16);
    check("KeyRd after timeout", 48'(KeyRd), 48'd1);
    check("result kept on timeout", 48'(result), 48'h4200);
    mac(16'h7777);
    @(negedge Clock);
    check("mac_done outside WAIT_DONE ignored", 48'(result), 48'h4200);
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
    check("clear resets timeout_err", 48'(timeout_err), 48'd0);

    // mac_done on the timeout cycle wins
    load_ops(16'h1111, 16'h2222, 16'h3333);
    wait_op_valid();
    do_ack();
    repeat (15) @(negedge Clock);
    exp_res.push_back(16'h5500);
    mac(16'h5500);
    check("no timeout when mac_done ties", 48'(timeout_err), 48'd0);
    check("result on tie", 48'(result), 48'h5500);

    // Two nibbles of A then clear with a simultaneous key pulse
    pulse_key(16'hC001);
    pulse_key(16'hC002);
    @(negedge Clock);
    clear = 1'b1;
    key_ready = 1'b1;
    key_word = 16'hFFFF;
    @(negedge Clock);
    clear = 1'b0;
    key_ready = 1'b0;
    key_word = '0;
    load_ops(16'h3E00, 16'h4500, 16'h3400);
    wait_op_valid();
    do_ack();
    exp_res.push_back(16'h4A80);
    mac(16'h4A80);

    // Async reset mid-handshake
    load_ops(16'h0001, 16'h0002, 16'h0003);
    wait_op_valid();
    #2 reset_n = 1'b0;
    #1 check("async reset clears op_valid/KeyRd", {46'd0, op_valid, KeyRd}, 48'd0);
    check("async reset clears op_a/result", {16'd0, op_a, result}, 48'd0);
    @(negedge Clock);
    reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    check("operand queue drained", 48'(exp_ops.size()), 48'd0);
    check("result queue drained", 48'(exp_res.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
